// File: rtl/limb_seq_pkg.sv
// Shared types and width helpers for the limb stream sequencer.
// ADDR_W / PASS_W here describe the default configuration; modules derive their own widths with the same functions.
package limb_seq_pkg;

    function automatic int addr_w_f(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    function automatic int pass_w_f(input int max_passes);
        return $clog2(max_passes + 1);
    endfunction

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_NUM_WORDS  = 64;
    localparam int DEF_MAX_PASSES = 16;
    localparam int ADDR_W         = addr_w_f(DEF_NUM_WORDS);
    localparam int PASS_W         = pass_w_f(DEF_MAX_PASSES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_FINISH
    } seq_state_t;

    typedef struct packed {
        logic [DEF_WORD_WIDTH-1:0] data;
        logic                      last;
        logic [PASS_W-1:0]         pass;
    } skid_entry_t;

endpackage

// File: rtl/limb_skid_buffer.sv
// Two-entry valid/ready skid buffer; the head register drives the consumer directly.
// flush empties both entries in one cycle and wins over a simultaneous write.
module limb_skid_buffer
    import limb_seq_pkg::*;
#(
    parameter type entry_t = skid_entry_t
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       flush,
    input  logic       wr_en,
    input  entry_t     wr_entry,
    input  logic       ready,
    output logic       valid,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t spare;
    logic   pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= 2'd0;
            head  <= '0;
            spare <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (wr_en) begin
                        head  <= wr_entry;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (wr_en && pop) begin
                        head <= wr_entry;
                    end else if (wr_en) begin
                        spare <= wr_entry;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: the spare slides into the head as the head is taken.
                    if (pop) begin
                        head <= spare;
                        if (wr_en) spare <= wr_entry;
                        else       count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/limb_stream_sequencer.sv
// Streams a NUM_WORDS-limb operand from a one-cycle-latency RAM onto a valid/ready bus, repeated for N passes.
//   state     | meaning
//   ST_IDLE   | waiting for start_in
//   ST_STREAM | issuing RAM reads while credit allows
//   ST_DRAIN  | all reads issued, waiting for the last word to handshake
//   ST_FINISH | one-cycle done_out pulse
module limb_stream_sequencer
    import limb_seq_pkg::*;
#(
    parameter  int WORD_WIDTH = 32,
    parameter  int NUM_WORDS  = 64,
    parameter  int MAX_PASSES = 16,
    localparam int ADDR_BITS  = addr_w_f(NUM_WORDS),
    localparam int PASS_BITS  = pass_w_f(MAX_PASSES)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [PASS_BITS-1:0]  passes_in,
    input  logic                  abort_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  rd_en_out,
    output logic [ADDR_BITS-1:0]  rd_addr_out,
    input  logic [WORD_WIDTH-1:0] rd_data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  last_out,
    output logic [PASS_BITS-1:0]  pass_idx_out
);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] data;
        logic                  last;
        logic [PASS_BITS-1:0]  pass;
    } entry_t;

    seq_state_t           state, state_nxt;
    logic [ADDR_BITS-1:0] addr;
    logic [PASS_BITS-1:0] pass_cnt, passes_lat, passes_sat;
    logic                 rd_pend, pend_last;
    logic [PASS_BITS-1:0] pend_pass;
    entry_t               wr_entry, head;
    logic                 skid_valid;
    logic [1:0]           skid_count;
    logic [2:0]           load;
    logic                 pop, issue, issue_final, last_addr, start_acc;

    assign passes_sat  = (passes_in > PASS_BITS'(MAX_PASSES)) ? PASS_BITS'(MAX_PASSES) : passes_in;
    assign start_acc   = (state == ST_IDLE) && start_in && !abort_in;
    assign pop         = skid_valid && ready_in;
    // Credit counts the slot freed by this cycle's pop so full-rate streaming never bubbles.
    assign load        = 3'(skid_count) - 3'(pop) + 3'(rd_pend);
    assign issue       = (state == ST_STREAM) && !abort_in && (load < 3'd2);
    assign last_addr   = (addr == ADDR_BITS'(NUM_WORDS - 1));
    assign issue_final = issue && last_addr && (pass_cnt == passes_lat - PASS_BITS'(1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_in) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_in) state_nxt = (passes_sat == '0) ? ST_FINISH : ST_STREAM;
                ST_STREAM: if (issue_final) state_nxt = ST_DRAIN;
                ST_DRAIN:  if (!rd_pend && ((skid_count == 2'd0) || (skid_count == 2'd1 && pop)))
                               state_nxt = ST_FINISH;
                ST_FINISH: state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_out  = (state != ST_IDLE);
        done_out  = (state == ST_FINISH) && !abort_in;
        rd_en_out = issue;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr       <= '0;
            pass_cnt   <= '0;
            passes_lat <= '0;
        end else if (start_acc) begin
            addr       <= '0;
            pass_cnt   <= '0;
            passes_lat <= passes_sat;
        end else if (issue) begin
            addr <= last_addr ? '0 : addr + ADDR_BITS'(1);
            if (last_addr) pass_cnt <= pass_cnt + PASS_BITS'(1);
        end
    end

    // Tags travel with the read so they line up with rd_data_in one cycle later.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            pend_pass <= '0;
        end else begin
            rd_pend <= issue && !abort_in;
            if (issue) begin
                pend_last <= last_addr;
                pend_pass <= pass_cnt;
            end
        end
    end

    assign rd_addr_out = addr;
    assign wr_entry    = '{data: rd_data_in, last: pend_last, pass: pend_pass};

    limb_skid_buffer #(.entry_t(entry_t)) u_skid (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (abort_in),
        .wr_en    (rd_pend),
        .wr_entry (wr_entry),
        .ready    (ready_in),
        .valid    (skid_valid),
        .head     (head),
        .count    (skid_count)
    );

    assign valid_out    = skid_valid;
    assign data_out     = head.data;
    assign last_out     = head.last;
    assign pass_idx_out = head.pass;

endmodule

// File: tb/tb_limb_stream_sequencer.sv
// Directed bench for limb_stream_sequencer with a RAM model and expected-beat / expected-address scoreboards.
module tb_limb_stream_sequencer;

    localparam int NW = 4;
    localparam int MP = 16;
    localparam int PB = 5;
    localparam int AB = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic [PB-1:0] passes_in = '0;
    logic          abort_in = 1'b0;
    logic          busy_out, done_out, rd_en_out, valid_out, last_out;
    logic          ready_in = 1'b1;
    logic [AB-1:0] rd_addr_out;
    logic [31:0]   rd_data_in = '0;
    logic [31:0]   data_out;
    logic [PB-1:0] pass_idx_out;

    logic [31:0]   mem [NW];
    logic [37:0]   sbq [$];
    logic [AB-1:0] aq [$];
    int checks = 0, failures = 0, beats = 0, done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_data = '0;

    always #5 clk_in = ~clk_in;

    limb_stream_sequencer #(.WORD_WIDTH(32), .NUM_WORDS(NW), .MAX_PASSES(MP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .passes_in(passes_in),
        .abort_in(abort_in), .busy_out(busy_out), .done_out(done_out), .rd_en_out(rd_en_out),
        .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in), .data_out(data_out),
        .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out), .pass_idx_out(pass_idx_out)
    );

    always @(posedge clk_in) rd_data_in <= rd_en_out ? mem[rd_addr_out] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (aq.size() == 0) begin
                if (rd_en_out) chk("rd_extra", rd_en_out, 0);
            end else if (rd_en_out) begin
                chk("rd_addr", rd_addr_out, aq.pop_front());
            end
            if (prev_stall) chk("stall_hold", {valid_out, data_out}, {1'b1, prev_data});
            if (valid_out && ready_in) begin
                beats++;
                if (sbq.size() == 0) chk("beat_extra", valid_out, 0);
                else chk("beat", {last_out, pass_idx_out, data_out}, sbq.pop_front());
            end
            prev_stall = valid_out && !ready_in && !abort_in;
            prev_data  = data_out;
            if (done_out) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_run(input int p);
        int eff;
        eff = (p > MP) ? MP : p;
        for (int ps = 0; ps < eff; ps++)
            for (int a = 0; a < NW; a++) begin
                logic [PB-1:0] pv;
                logic [AB-1:0] av;
                pv = PB'(ps);
                av = AB'(a);
                sbq.push_back({(a == NW - 1), pv, mem[a]});
                aq.push_back(av);
            end
        passes_in = PB'(p);
        start_in  = 1'b1;
        tick();
        start_in  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (!done_out && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done_out, 1);
        chk("queue_empty", sbq.size(), 0);
        tick();
        chk("done_pulse_one", done_out, 0);
        chk("idle_after_done", busy_out, 0);
    endtask

    initial begin
        int n, b0, d0;
        for (int i = 0; i < NW; i++) mem[i] = $urandom;

        // Reset values
        #3;
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_addr", rd_addr_out, 0);
        chk("rst_pass", pass_idx_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        tick();
        rst_in = 1'b1;
        tick();

        // Two passes, ready high: latency and done timing
        b0 = beats;
        start_run(2);
        chk("t1_busy", busy_out, 1);
        chk("t1_rd_en_first", rd_en_out, 1);
        chk("t1_valid_n1", valid_out, 0);
        tick();
        chk("t1_valid_n1b", valid_out, 0);
        tick();
        chk("t1_valid_n2", valid_out, 1);
        wait_done("t1_done", 50, n);
        chk("t1_done_cycle", n, 8);
        chk("t1_beats", beats - b0, 8);

        // Zero passes
        start_run(0);
        chk("t2_done", done_out, 1);
        chk("t2_busy", busy_out, 1);
        chk("t2_no_rd", rd_en_out, 0);
        tick();
        chk("t2_done_low", done_out, 0);
        chk("t2_busy_low", busy_out, 0);

        // Random backpressure
        b0 = beats;
        start_run(3);
        n = 0;
        while (!done_out && n < 400) begin
            ready_in = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready_in = 1'b1;
        chk("t3_done", done_out, 1);
        chk("t3_beats", beats - b0, 12);
        chk("t3_queue_empty", sbq.size(), 0);
        tick();

        // Abort after beat 3
        b0 = beats;
        start_run(2);
        n = 0;
        while (beats - b0 < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("t4_three_beats", beats - b0, 3);
        abort_in = 1'b1;
        ready_in = 1'b0;
        tick();
        abort_in = 1'b0;
        sbq.delete();
        aq.delete();
        chk("t4_idle", busy_out, 0);
        chk("t4_valid", valid_out, 0);
        chk("t4_done", done_out, 0);
        d0 = done_cnt;
        repeat (4) tick();
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_still_invalid", valid_out, 0);
        ready_in = 1'b1;
        b0 = beats;
        start_run(2);
        wait_done("t4_rerun_done", 50, n);
        chk("t4_rerun_beats", beats - b0, 8);

        // Start while busy is ignored
        b0 = beats;
        start_run(2);
        repeat (3) tick();
        passes_in = PB'(5);
        start_in  = 1'b1;
        tick();
        start_in  = 1'b0;
        wait_done("t5_done", 50, n);
        repeat (3) tick();
        chk("t5_beats", beats - b0, 8);

        // Saturated pass count
        b0 = beats;
        start_run(MP + 3);
        wait_done("t6_done", 300, n);
        chk("t6_beats", beats - b0, NW * MP);

        // Reset mid-run
        start_run(2);
        repeat (4) tick();
        rst_in = 1'b0;
        #1;
        chk("t7_valid", valid_out, 0);
        chk("t7_data", data_out, 0);
        chk("t7_last", last_out, 0);
        chk("t7_pass", pass_idx_out, 0);
        chk("t7_rd_en", rd_en_out, 0);
        chk("t7_addr", rd_addr_out, 0);
        chk("t7_busy", busy_out, 0);
        chk("t7_done", done_out, 0);
        sbq.delete();
        aq.delete();
        tick();
        rst_in = 1'b1;
        tick();
        chk("t7_idle_after", busy_out, 0);
        b0 = beats;
        start_run(1);
        wait_done("t7_rerun_done", 50, n);
        chk("t7_rerun_beats", beats - b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
